// File: rtl/inv_round_stage.sv
// Elastic two-stage AES-128 inverse round: key add and optional InvMixColumns into stage A,
// then InvShiftRows and InvSubBytes into stage B. Valid/ready handshake on both sides.
module inv_round_stage #(
  parameter int BLOCK_LENGTH = 128,
  parameter bit MIX          = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BLOCK_LENGTH-1:0] IN,
  input  logic [BLOCK_LENGTH-1:0] KEY,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BLOCK_LENGTH-1:0] OUT
);

  localparam int NB = BLOCK_LENGTH / 8;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = '0;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254; zero maps to zero for free.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] acc;
    logic [7:0] sq;
    acc = 8'h01;
    sq  = a;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  // Inverse affine transform followed by field inversion.
  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] t;
    t = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

  function automatic logic [BLOCK_LENGTH-1:0] key_add(input logic [BLOCK_LENGTH-1:0] s,
                                                      input logic [BLOCK_LENGTH-1:0] k);
    return s ^ k;
  endfunction

  function automatic logic [BLOCK_LENGTH-1:0] inv_mix_columns(input logic [BLOCK_LENGTH-1:0] s);
    logic [BLOCK_LENGTH-1:0] r;
    logic [7:0] a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < NB / 4; c++) begin
      a0 = s[BLOCK_LENGTH-1-8*(4*c)   -: 8];
      a1 = s[BLOCK_LENGTH-1-8*(4*c+1) -: 8];
      a2 = s[BLOCK_LENGTH-1-8*(4*c+2) -: 8];
      a3 = s[BLOCK_LENGTH-1-8*(4*c+3) -: 8];
      r[BLOCK_LENGTH-1-8*(4*c)   -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      r[BLOCK_LENGTH-1-8*(4*c+1) -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      r[BLOCK_LENGTH-1-8*(4*c+2) -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      r[BLOCK_LENGTH-1-8*(4*c+3) -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return r;
  endfunction

  // Row r rotates right by r columns; byte index is column*4 + row.
  function automatic logic [BLOCK_LENGTH-1:0] inv_shift_rows(input logic [BLOCK_LENGTH-1:0] s);
    logic [BLOCK_LENGTH-1:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int w = 0; w < 4; w++) begin
        r[BLOCK_LENGTH-1-8*(4*c+w) -: 8] = s[BLOCK_LENGTH-1-8*(4*((c+4-w)%4)+w) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [BLOCK_LENGTH-1:0] inv_sub_bytes(input logic [BLOCK_LENGTH-1:0] s);
    logic [BLOCK_LENGTH-1:0] r;
    r = '0;
    for (int i = 0; i < NB; i++) begin
      r[BLOCK_LENGTH-1-8*i -: 8] = inv_sbox(s[BLOCK_LENGTH-1-8*i -: 8]);
    end
    return r;
  endfunction

  logic                    a_valid;
  logic [BLOCK_LENGTH-1:0] a_data;
  logic [BLOCK_LENGTH-1:0] key_d;
  logic [BLOCK_LENGTH-1:0] mix_d;
  logic [BLOCK_LENGTH-1:0] sub_d;
  logic                    b_ready;
  logic                    accept;
  logic                    advance;

  assign key_d = key_add(IN, KEY);
  assign mix_d = MIX ? inv_mix_columns(key_d) : key_d;
  assign sub_d = inv_sub_bytes(inv_shift_rows(a_data));

  // in_ready is combinational on out_ready, so the pipe refills on the same edge it drains.
  assign b_ready  = !out_valid || out_ready;
  assign in_ready = !a_valid || b_ready;
  assign accept   = in_valid && in_ready;
  assign advance  = a_valid && b_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_valid   <= 1'b0;
      a_data    <= '0;
      out_valid <= 1'b0;
      OUT       <= '0;
    end else begin
      if (accept) begin
        a_data  <= mix_d;
        a_valid <= 1'b1;
      end else if (b_ready) begin
        a_valid <= 1'b0;
      end
      if (advance) begin
        OUT       <= sub_d;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inv_round_stage.sv
// Bench for inv_round_stage: table-driven AES reference (log/antilog field arithmetic,
// S-box inverted by lookup) with per-cycle scoreboards on a MIX=0 and a MIX=1 instance.
module tb_inv_round_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         in_valid0, in_ready0, out_valid0, out_ready0;
  logic [127:0] in0, key0, out0;
  logic         in_valid1, in_ready1, out_valid1, out_ready1;
  logic [127:0] in1, key1, out1;

  inv_round_stage #(.BLOCK_LENGTH(128), .MIX(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .IN(in0), .KEY(key0),
    .out_valid(out_valid0), .out_ready(out_ready0), .OUT(out0));

  inv_round_stage #(.BLOCK_LENGTH(128), .MIX(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .IN(in1), .KEY(key1),
    .out_valid(out_valid1), .out_ready(out_ready1), .OUT(out1));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] exp_t[256];
  int         log_t[256];
  logic [7:0] sbox[256];
  logic [7:0] isbox[256];

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] t;
    t = {v, v} << n;
    return t[15:8];
  endfunction

  task automatic build_tables();
    logic [7:0] x, inv, s;
    x = 8'h01;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = x;
      log_t[x] = i;
      x = x ^ ({x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00));
    end
    exp_t[255] = exp_t[0];
    for (int a = 0; a < 256; a++) begin
      inv = (a == 0) ? 8'h00 : exp_t[(255 - log_t[a]) % 255];
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox[a] = s;
      isbox[s] = 8'(a);
    end
  endtask

  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    if (a == 0 || b == 0) return 8'h00;
    return exp_t[(log_t[a] + log_t[b]) % 255];
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col, input bit inv);
    logic [7:0]  rc[4];
    logic [31:0] r;
    logic [7:0]  acc;
    if (inv) begin rc[0] = 8'h0e; rc[1] = 8'h0b; rc[2] = 8'h0d; rc[3] = 8'h09; end
    else     begin rc[0] = 8'h02; rc[1] = 8'h03; rc[2] = 8'h01; rc[3] = 8'h01; end
    r = '0;
    for (int row = 0; row < 4; row++) begin
      acc = 8'h00;
      for (int j = 0; j < 4; j++) acc = acc ^ mul(rc[(j - row + 4) % 4], col[31-8*j -: 8]);
      r[31-8*row -: 8] = acc;
    end
    return r;
  endfunction

  function automatic logic [127:0] model_inv(input logic [127:0] x, input logic [127:0] k, input bit mix);
    logic [127:0] m, o;
    m = x ^ k;
    if (mix) for (int c = 0; c < 4; c++) m[127-32*c -: 32] = mix_col(m[127-32*c -: 32], 1'b1);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = isbox[m[127-8*(4*((c-r+4)%4)+r) -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] fwd_round(input logic [127:0] x, input logic [127:0] k, input bit mix);
    logic [127:0] t;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[127-8*(4*c+r) -: 8] = sbox[x[127-8*(4*((c+r)%4)+r) -: 8]];
    if (mix) for (int c = 0; c < 4; c++) t[127-32*c -: 32] = mix_col(t[127-32*c -: 32], 1'b0);
    return t ^ k;
  endfunction

  // ---------------- scoreboards ----------------
  logic [127:0] exp0_q[$];
  logic [127:0] exp1_q[$];
  logic [127:0] orig_q[$];
  int n_in0 = 0, n_out0 = 0, n_out1 = 0;

  initial begin : mon0
    logic [127:0] prev_out;
    bit prev_hold;
    prev_hold = 1'b0;
    prev_out  = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp0_q.delete();
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          chk("hold_valid", out_valid0, 1'b1);
          chk("hold_data", out0, prev_out);
        end
        if (out_valid0) begin
          if (exp0_q.size() == 0) begin
            chk("unexpected_out0", out_valid0, 1'b0);
          end else begin
            chk("out0_data", out0, exp0_q[0]);
            if (out_ready0) begin
              void'(exp0_q.pop_front());
              n_out0++;
            end
          end
        end
        if (in_valid0 && in_ready0) begin
          exp0_q.push_back(model_inv(in0, key0, 1'b0));
          n_in0++;
        end
        prev_hold = out_valid0 && !out_ready0;
        prev_out  = out0;
      end
    end
  end

  initial begin : mon1
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp1_q.delete();
      end else begin
        if (out_valid1) begin
          if (exp1_q.size() == 0) begin
            chk("unexpected_out1", out_valid1, 1'b0);
          end else begin
            chk("out1_model", out1, exp1_q[0]);
            if (out_ready1) begin
              void'(exp1_q.pop_front());
              if (orig_q.size() != 0) chk("out1_roundtrip", out1, orig_q.pop_front());
              n_out1++;
            end
          end
        end
        if (in_valid1 && in_ready1) exp1_q.push_back(model_inv(in1, key1, 1'b1));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit which, input logic [127:0] d, input logic [127:0] k);
    bit acc;
    acc = 1'b0;
    if (which) begin in_valid1 = 1'b1; in1 = d; key1 = k; end
    else       begin in_valid0 = 1'b1; in0 = d; key0 = k; end
    for (int t = 0; t < 200 && !acc; t++) begin
      #1;
      acc = which ? in_ready1 : in_ready0;
      tick();
    end
    if (!acc) chk("send_timeout", 1'b0, 1'b1);
    if (which) in_valid1 = 1'b0;
    else       in_valid0 = 1'b0;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  logic [127:0] blk[4];
  bit rnd_done;
  int n0, i0;

  initial begin
    build_tables();
    rst = 1'b0;
    in_valid0 = 1'b1; in0 = 128'h00112233445566778899aabbccddeeff; key0 = 128'h0f0e0d0c0b0a09080706050403020100;
    out_ready0 = 1'b1;
    in_valid1 = 1'b0; in1 = '0; key1 = '0; out_ready1 = 1'b1;

    // Model pins: FIPS-197 field product, S-box entries, MixColumns vector, final-round pair.
    chk("pin_mul", mul(8'h57, 8'h83), 8'hc1);
    chk("pin_sbox53", sbox[8'h53], 8'hed);
    chk("pin_isbox63", isbox[8'h63], 8'h00);
    chk("pin_mixcol", mix_col(32'hdb135345, 1'b0), 32'h8e4da1bc);
    chk("pin_invmixcol", mix_col(32'h8e4da1bc, 1'b1), 32'hdb135345);
    chk("pin_fwd_final", fwd_round(128'hbd6e7c3df2b5779e0b61216e8b10b689,
                                   128'h13111d7fe3944a17f307a78b4d2b30c5, 1'b0),
        128'h69c4e0d86a7b0430d8cdb78070b4c55a);

    // Reset held with in_valid asserted.
    repeat (3) tick();
    chk("rst_out_valid", out_valid0, 1'b0);
    chk("rst_out", out0, '0);
    chk("rst_out1_valid", out_valid1, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst_in_ready", in_ready0, 1'b1);
    n0 = n_out0;
    tick();
    in_valid0 = 1'b0;
    repeat (4) tick();
    chk("rst_first_count", n_out0 - n0, 1);

    // Known answer: undoing round 10 of FIPS-197 C.1 yields the round-10 start state.
    in_valid0 = 1'b1;
    in0  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    key0 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    tick();
    in_valid0 = 1'b0;
    chk("kat_lat_n", out_valid0, 1'b0);
    tick();
    chk("kat_valid", out_valid0, 1'b1);
    chk("kat_out", out0, 128'hbd6e7c3df2b5779e0b61216e8b10b689);
    tick();
    chk("kat_one_cycle", out_valid0, 1'b0);

    // Back-pressure: only two blocks fit.
    for (int i = 0; i < 4; i++) blk[i] = rnd128() ^ 128'(i);
    out_ready0 = 1'b0;
    i0 = n_in0;
    n0 = n_out0;
    send(1'b0, blk[0], ~blk[0]);
    send(1'b0, blk[1], ~blk[1]);
    in_valid0 = 1'b1; in0 = blk[2]; key0 = ~blk[2];
    #1;
    chk("bp_full_ready", in_ready0, 1'b0);
    repeat (3) tick();
    chk("bp_still_full", in_ready0, 1'b0);
    chk("bp_accepts", n_in0 - i0, 2);
    out_ready0 = 1'b1;
    send(1'b0, blk[2], ~blk[2]);
    send(1'b0, blk[3], ~blk[3]);
    repeat (5) tick();
    chk("bp_drained", n_out0 - n0, 4);

    // Random traffic with random stalls on both sides.
    n0 = n_out0;
    rnd_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 1000; n++) begin
          repeat ($urandom_range(0, 1)) tick();
          send(1'b0, rnd128(), rnd128());
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          out_ready0 = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join
    out_ready0 = 1'b1;
    repeat (6) tick();
    chk("rnd_count", n_out0 - n0, 1000);
    chk("rnd_queue_empty", exp0_q.size(), 0);

    // Mid-flight reset discards both blocks.
    out_ready0 = 1'b0;
    send(1'b0, rnd128(), rnd128());
    send(1'b0, rnd128(), rnd128());
    #1;
    chk("mf_full", in_ready0, 1'b0);
    n0 = n_out0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("mf_out_valid", out_valid0, 1'b0);
    out_ready0 = 1'b1;
    #1;
    chk("mf_in_ready", in_ready0, 1'b1);
    repeat (5) tick();
    chk("mf_no_output", n_out0 - n0, 0);

    // Middle-round round trip on the MIX=1 instance.
    n0 = n_out1;
    for (int n = 0; n < 100; n++) begin
      logic [127:0] s, k;
      s = rnd128();
      k = rnd128();
      orig_q.push_back(s);
      send(1'b1, fwd_round(s, k, 1'b1), k);
    end
    repeat (5) tick();
    chk("rt_count", n_out1 - n0, 100);
    chk("rt_queue_empty", orig_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
